// File: rtl/core_loader.sv
// Per-core task receiver: watches the scheduler bus, captures r0 init words and
// buffers the instruction stream for this core, then launches execution.
module core_loader #(
  parameter int                     CORE_ID     = 0,
  parameter int                     CORE_NUM    = 16,
  parameter int                     BUS_TO_CORE = 16,
  parameter int                     R0_WORDS    = 13,
  parameter int                     IBUF_DEPTH  = 64,
  parameter logic [BUS_TO_CORE-1:0] END_OPCODE  = 16'hFFFF,
  localparam int                    AW          = $clog2(IBUF_DEPTH)
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [BUS_TO_CORE-1:0]          mess_to_core_i,
  input  logic                            core_mask_loading_i,
  input  logic                            r0_mask_loading_i,
  input  logic                            r0_loading_i,
  input  logic                            instr_loading_i,
  output logic                            core_reading_o,
  output logic                            core_ready_o,
  output logic [R0_WORDS*BUS_TO_CORE-1:0] r0_data_o,
  output logic                            r0_valid_o,
  output logic                            exec_start_o,
  input  logic                            exec_done_i,
  input  logic [AW-1:0]                   ibuf_raddr_i,
  output logic [BUS_TO_CORE-1:0]          ibuf_rdata_o,
  output logic [AW:0]                     ibuf_count_o,
  output logic                            proto_err_o
);

  localparam int              R0PW    = $clog2(R0_WORDS + 1);
  localparam logic [R0PW-1:0] R0_FULL = R0PW'(R0_WORDS);
  localparam logic [AW:0]     DEPTH_C = (AW + 1)'(IBUF_DEPTH);
  localparam logic [AW:0]     LAST_C  = (AW + 1)'(IBUF_DEPTH - 1);
  localparam int              OWN_BIT = (CORE_ID < CORE_NUM) ? CORE_ID : 0;

  typedef enum logic [1:0] {ST_IDLE, ST_R0_LOAD, ST_INSTR_LOAD, ST_EXEC} state_e;

  state_e                            state_q;
  logic                              r0_sel_q;
  logic [R0PW-1:0]                   r0_ptr_q;
  logic [AW-1:0]                     wr_ptr_q;
  logic [AW:0]                       ibuf_count_q;
  logic [R0_WORDS*BUS_TO_CORE-1:0]   r0_data_q;
  logic                              r0_valid_q;
  logic                              exec_start_q;
  logic                              core_ready_q;
  logic                              proto_err_q;
  logic [BUS_TO_CORE-1:0]            ibuf_rdata_q;
  logic [BUS_TO_CORE-1:0]            ibuf_q [IBUF_DEPTH];

  logic multi_s, own_s, cm_s, r0m_s, r0w_s, ins_s;
  logic loading_s, ibuf_we_s, load_end_s, start_task_s, abort_s;

  // Strobe decode: a word carried under more than one strobe is discarded.
  always_comb begin
    multi_s      = ($countones({core_mask_loading_i, r0_mask_loading_i,
                                r0_loading_i, instr_loading_i}) > 1);
    own_s        = mess_to_core_i[OWN_BIT];
    cm_s         = core_mask_loading_i && !multi_s;
    r0m_s        = r0_mask_loading_i && !multi_s;
    r0w_s        = r0_loading_i && !multi_s;
    ins_s        = instr_loading_i && !multi_s;
    loading_s    = (state_q == ST_R0_LOAD) || (state_q == ST_INSTR_LOAD);
    ibuf_we_s    = ins_s && loading_s && (ibuf_count_q != DEPTH_C);
    load_end_s   = ibuf_we_s && ((mess_to_core_i == END_OPCODE) || (ibuf_count_q == LAST_C));
    start_task_s = cm_s && own_s && (state_q != ST_EXEC);
    abort_s      = cm_s && !own_s && loading_s;
  end

  // Task FSM with all registered status outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      r0_sel_q     <= 1'b0;
      r0_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      ibuf_count_q <= '0;
      r0_data_q    <= '0;
      r0_valid_q   <= 1'b0;
      exec_start_q <= 1'b0;
      core_ready_q <= 1'b1;
      proto_err_q  <= 1'b0;
    end else begin
      exec_start_q <= 1'b0;
      if (multi_s || (cm_s && own_s && state_q != ST_IDLE) || abort_s) begin
        proto_err_q <= 1'b1;
      end
      if (start_task_s) begin
        // A new mask hit restarts cleanly, including on top of a partial load.
        state_q      <= ST_R0_LOAD;
        r0_sel_q     <= 1'b0;
        r0_ptr_q     <= '0;
        wr_ptr_q     <= '0;
        ibuf_count_q <= '0;
        r0_data_q    <= '0;
        r0_valid_q   <= 1'b0;
      end else if (abort_s) begin
        state_q      <= ST_IDLE;
        ibuf_count_q <= '0;
        r0_valid_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: state_q <= ST_IDLE;
          ST_R0_LOAD, ST_INSTR_LOAD: begin
            if (state_q == ST_R0_LOAD && r0m_s) begin
              r0_sel_q <= own_s;
            end else if (state_q == ST_R0_LOAD && r0w_s && r0_sel_q && r0_ptr_q != R0_FULL) begin
              r0_data_q[int'(r0_ptr_q)*BUS_TO_CORE +: BUS_TO_CORE] <= mess_to_core_i;
              r0_ptr_q <= r0_ptr_q + 1'b1;
            end else if (ibuf_we_s) begin
              wr_ptr_q     <= wr_ptr_q + 1'b1;
              ibuf_count_q <= ibuf_count_q + 1'b1;
              if (state_q == ST_R0_LOAD) begin
                r0_valid_q <= r0_sel_q;
              end
              if (load_end_s) begin
                state_q      <= ST_EXEC;
                exec_start_q <= 1'b1;
                core_ready_q <= 1'b0;
              end else begin
                state_q <= ST_INSTR_LOAD;
              end
            end
          end
          ST_EXEC: begin
            if (exec_done_i) begin
              state_q      <= ST_IDLE;
              core_ready_q <= 1'b1;
              ibuf_count_q <= '0;
              r0_valid_q   <= 1'b0;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Instruction buffer write port; contents are not cleared between tasks.
  always_ff @(posedge clk_i) begin
    if (ibuf_we_s && !reset_i) begin
      ibuf_q[wr_ptr_q] <= mess_to_core_i;
    end
  end

  // Registered read port, active in every state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ibuf_rdata_q <= '0;
    end else begin
      ibuf_rdata_q <= ibuf_q[ibuf_raddr_i];
    end
  end

  assign core_reading_o = (state_q != ST_EXEC) && (ibuf_count_q != DEPTH_C);
  assign core_ready_o   = core_ready_q;
  assign r0_data_o      = r0_data_q;
  assign r0_valid_o     = r0_valid_q;
  assign exec_start_o   = exec_start_q;
  assign ibuf_rdata_o   = ibuf_rdata_q;
  assign ibuf_count_o   = ibuf_count_q;
  assign proto_err_o    = proto_err_q;

endmodule

// File: doc/core_loader.md
Name: core_loader

Overview:
Per-core receiver that sits directly downstream of the scheduler. It consumes the scheduler's message bus and its four loading strobes, and decides whether the current task targets this core. For a targeted core it captures the r0 initial data and buffers the instruction stream, then hands the task to the execution pipeline. It reports back to the scheduler through core_reading (can accept words) and core_ready (idle).

Parameters:
CORE_ID, 0, index of this core; selects the bit tested in mask words.
CORE_NUM, 16, number of cores; width of mask words on the bus.
BUS_TO_CORE, 16, width of mess_to_core in bits (one word).
R0_WORDS, 13, r0 data words per task (frame slots 3..15).
IBUF_DEPTH, 64, instruction buffer depth in words (power of 2).
END_OPCODE, 16'hFFFF, instruction word that terminates a program.

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
mess_to_core  input  BUS_TO_CORE  message word from the scheduler
core_mask_loading  input  1  word is the task core mask
r0_mask_loading  input  1  word is the r0-init mask
r0_loading  input  1  word is an r0 data word
instr_loading  input  1  word is an instruction word
core_reading  output  1  can accept a word this cycle
core_ready  output  1  core idle (scheduler derives exec_mask = ~core_ready)
r0_data  output  R0_WORDS*BUS_TO_CORE  captured r0 words, word i at bits [i*BUS_TO_CORE +: BUS_TO_CORE]
r0_valid  output  1  r0_data holds this task's init data
exec_start  output  1  one-cycle pulse that launches execution
exec_done  input  1  execution pipeline finished the task
ibuf_raddr  input  log2(IBUF_DEPTH)  instruction read address
ibuf_rdata  output  BUS_TO_CORE  instruction word, registered, 1-cycle latency
ibuf_count  output  log2(IBUF_DEPTH)+1  number of valid instruction words
proto_err  output  1  sticky protocol-violation flag

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Values after reset:
  - State is IDLE.
  - core_ready=1, core_reading=1.
  - r0_valid=0, exec_start=0, proto_err=0.
  - ibuf_count=0, r0_data=0, ibuf_rdata=0.
  - All pointers and counters are 0.
  - Reset mid-load or mid-exec drops the task; no exec_start is issued.
- Strobe handling:
  - At most one loading strobe is high per cycle. Two or more high at once sets proto_err and the word is ignored.
  - Words are taken only when their strobe is high and sampled on that same clock edge.
- States: IDLE, R0_LOAD, INSTR_LOAD, EXEC.
- IDLE:
  - On core_mask_loading with mess_to_core[CORE_ID]=1: latch sel=1, clear r0 and instruction pointers, clear r0_valid, go to R0_LOAD.
  - If that bit is 0: stay in IDLE and ignore all r0/instr words until the next core_mask_loading.
- R0_LOAD:
  - r0_mask_loading latches r0_sel = mess_to_core[CORE_ID].
  - Each r0_loading word is written to slot r0_ptr, then r0_ptr++, but only when r0_sel=1. Words arriving after r0_ptr has reached R0_WORDS are dropped.
  - The first instr_loading word moves the block to INSTR_LOAD and is also stored as an instruction.
  - r0_valid=1 from the cycle after the first instruction is stored, if r0_sel=1.
- INSTR_LOAD:
  - Each instr_loading word is written to ibuf[wr_ptr], then wr_ptr++ and ibuf_count++.
  - A word equal to END_OPCODE is stored and ends the load.
  - A write that makes ibuf_count = IBUF_DEPTH also ends the load.
  - On load end: go to EXEC; exec_start=1 on the next cycle only.
- core_reading:
  - 0 in EXEC.
  - 0 when ibuf_count = IBUF_DEPTH.
  - 1 otherwise, combinational from registered state.
  - Non-selected cores hold core_reading=1 so the scheduler is never stalled by them.
- EXEC:
  - core_ready=0 from the cycle exec_start is high until return to IDLE.
  - exec_done high → next cycle IDLE, core_ready=1, ibuf_count=0, r0_valid=0.
  - exec_done outside EXEC is ignored.
  - Instruction buffer contents persist until overwritten.
- Violations (each sets proto_err; proto_err clears only on reset):
  - core_mask_loading with own bit set during EXEC: the word is ignored.
  - core_mask_loading with own bit set during R0_LOAD or INSTR_LOAD: the partial task is aborted and the new task starts in R0_LOAD.
  - core_mask_loading with own bit clear during R0_LOAD or INSTR_LOAD: the partial task is aborted and the block returns to IDLE.
- ibuf read port: ibuf_rdata <= ibuf[ibuf_raddr] every cycle, in any state.

Test Plan:
- Basic task:
  - Stimulus: core_mask word 16'h0001 (CORE_ID=0); r0_mask 16'h0001; 13 r0 words 16'h1000..16'h100C; 16 instructions 16'h2000..16'h200E then 16'hFFFF.
  - Required: r0_data slot i = 16'h1000+i; ibuf_count=16; exec_start pulses exactly once, one cycle after the FFFF word; core_ready falls with exec_start; core_reading=0; after exec_done, core_ready=1 next cycle.
- Non-selected core:
  - Stimulus: core_mask 16'h0002 with CORE_ID=0, followed by r0 and instruction words.
  - Required: r0_valid=0, ibuf_count=0, exec_start never pulses, core_reading=1 and core_ready=1 throughout.
- r0 not requested:
  - Stimulus: core_mask 16'h0001, r0_mask 16'h0000, then the r0 words.
  - Required: r0_data stays 0; r0_valid=0 after instructions load.
- Buffer full:
  - Stimulus: IBUF_DEPTH=64; 64 instruction words with no END_OPCODE.
  - Required: core_reading=0 in the cycle after the 64th write; exec_start pulses; a 65th word is not stored.
- Violations:
  - Stimulus: in EXEC, core_mask 16'h0001, then exec_done.
  - Required: proto_err=1; state unchanged until exec_done.
  - Stimulus: two strobes high together.
  - Required: proto_err=1; word dropped.
- Reset mid-load:
  - Stimulus: reset asserted after 5 instructions.
  - Required: ibuf_count=0, state IDLE, exec_start never pulses.
- Read latency:
  - Stimulus: ibuf_raddr=3 after the basic task.
  - Required: ibuf_rdata=16'h2003 one cycle later.
